// File: rtl/microwave_pkg.sv
// Shared constants and state encoding for the microwave countdown controller.
package microwave_pkg;

    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned BCD_MAX      = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTRY = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/microwave_timer_ctrl_digit.sv
// timer_digit: one BCD down-counter digit with a configurable modulus.
//   clk, clrn : clock, async active-low reset
//   load, din : synchronous load (wins over en)
//   en        : count down one step
//   q         : registered digit value
//   zero      : q == 0
//   borrow    : combinational, en && q == 0 (wrap to MODULUS-1, feeds next digit)
module timer_digit
    import microwave_pkg::*;
#(
    parameter int unsigned MODULUS = 10
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] din,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               zero,
    output logic               borrow
);

    assign zero   = (q == '0);
    assign borrow = en && zero;

    // Load has priority; counting wraps 0 -> MODULUS-1.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (en) begin
            q <= zero ? DIGIT_W'(MODULUS - 1) : q - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Microwave countdown sequencer: keypad entry into M:SS, run/pause/done FSM
// on a 1 Hz tick, magnetron enable and end-of-cook indication.
//   clk, clrn            : clock, async active-low reset
//   tick                 : 1 Hz enable pulse
//   key_valid, key_data  : keypad digit strobe
//   start, stop, clear   : one-cycle requests
//   door_closed          : door level, 1 = closed
//   min_ones, sec_tens, sec_ones : displayed time
//   mag_on, done, state  : magnetron enable, end-of-cook, FSM state
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned DONE_TICKS = 3,
    parameter int unsigned MAX_MIN    = 9
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               tick,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_data,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               door_closed,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               mag_on,
    output logic               done,
    output logic [2:0]         state
);

    localparam int unsigned CNT_W = 4;

    state_t             st_q, st_d;
    logic               mag_d, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ld, count_en;
    logic [DIGIT_W-1:0] min_din, tens_din, ones_din;
    logic               min_zero, tens_zero, ones_zero;
    logic               ones_borrow, tens_borrow, unused_borrow;
    logic               time_zero, time_one, key_ok, can_start;

    assign time_zero = min_zero && tens_zero && ones_zero;
    assign time_one  = min_zero && tens_zero && (sec_ones == DIGIT_W'(1));
    // Old sec_ones becomes sec_tens and old sec_tens becomes min_ones.
    assign key_ok    = key_valid
                    && (key_data <= DIGIT_W'(BCD_MAX))
                    && (sec_ones <= DIGIT_W'(SEC_TENS_MAX))
                    && (sec_tens <= DIGIT_W'(MAX_MIN));
    assign can_start = start && door_closed && !time_zero;

    assign state = st_q;

    // Digit chain: sec_ones -> sec_tens -> min_ones via borrow.
    timer_digit #(.MODULUS(10)) u_sec_ones (
        .clk(clk), .clrn(clrn), .load(ld), .din(ones_din), .en(count_en),
        .q(sec_ones), .zero(ones_zero), .borrow(ones_borrow)
    );
    timer_digit #(.MODULUS(6)) u_sec_tens (
        .clk(clk), .clrn(clrn), .load(ld), .din(tens_din), .en(ones_borrow),
        .q(sec_tens), .zero(tens_zero), .borrow(tens_borrow)
    );
    // A borrow out of the minutes digit cannot occur: RUN is left at 0:00.
    timer_digit #(.MODULUS(10)) u_min_ones (
        .clk(clk), .clrn(clrn), .load(ld), .din(min_din), .en(tens_borrow),
        .q(min_ones), .zero(min_zero), .borrow(unused_borrow)
    );

    // State, magnetron, done flag and done-tick counter registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st_q   <= IDLE;
            mag_on <= 1'b0;
            done   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            st_q   <= st_d;
            mag_on <= mag_d;
            done   <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    // Next state with priority clear > stop/door > start > key > tick.
    always_comb begin
        st_d     = st_q;
        mag_d    = mag_on;
        done_d   = done;
        cnt_d    = cnt_q;
        ld       = 1'b0;
        count_en = 1'b0;
        min_din  = sec_tens;
        tens_din = sec_ones;
        ones_din = key_data;

        if (clear) begin
            st_d     = IDLE;
            mag_d    = 1'b0;
            done_d   = 1'b0;
            cnt_d    = '0;
            ld       = 1'b1;
            min_din  = '0;
            tens_din = '0;
            ones_din = '0;
        end else begin
            case (st_q)
                IDLE, ENTRY: begin
                    if (!stop) begin
                        if (start) begin
                            if (can_start) begin
                                st_d  = RUN;
                                mag_d = 1'b1;
                            end
                        end else if (key_ok) begin
                            ld   = 1'b1;
                            st_d = ENTRY;
                        end
                    end
                end
                PAUSE: begin
                    if (!stop && can_start) begin
                        st_d  = RUN;
                        mag_d = 1'b1;
                    end
                end
                RUN: begin
                    if (stop || !door_closed) begin
                        st_d  = PAUSE;
                        mag_d = 1'b0;
                    end else if (tick) begin
                        count_en = 1'b1;
                        if (time_one) begin
                            st_d   = DONE;
                            mag_d  = 1'b0;
                            done_d = 1'b1;
                            cnt_d  = '0;
                        end
                    end
                end
                DONE: begin
                    if (tick) begin
                        if (cnt_q == CNT_W'(DONE_TICKS - 1)) begin
                            st_d   = IDLE;
                            done_d = 1'b0;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    st_d   = IDLE;
                    mag_d  = 1'b0;
                    done_d = 1'b0;
                    cnt_d  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Scoreboard bench: a driver applies one input set per cycle and pushes the
// reference model's expected outputs; a monitor pops and compares each cycle.
module tb_microwave_timer_ctrl;

    localparam int DONE_TICKS = 3;
    localparam int MAX_MIN    = 9;
    localparam int S_IDLE = 0, S_ENTRY = 1, S_RUN = 2, S_PAUSE = 3, S_DONE = 4;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic       tick = 1'b0, key_valid = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [3:0] key_data = 4'd0;
    logic       door_closed = 1'b1;
    logic [3:0] min_ones, sec_tens, sec_ones;
    logic       mag_on, done;
    logic [2:0] state;

    microwave_timer_ctrl #(.DONE_TICKS(DONE_TICKS), .MAX_MIN(MAX_MIN)) dut (
        .clk(clk), .clrn(clrn), .tick(tick), .key_valid(key_valid),
        .key_data(key_data), .start(start), .stop(stop), .clear(clear),
        .door_closed(door_closed), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .mag_on(mag_on), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int m;
        int t;
        int o;
        bit mag;
        bit dn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: digits for entry, total seconds for countdown.
    int   m_st = S_IDLE, m_m = 0, m_t = 0, m_o = 0, m_cnt = 0;
    bit   m_mag = 0, m_dn = 0;
    bit   door = 1'b1;

    function automatic int secs();
        return m_m * 60 + m_t * 10 + m_o;
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_m = 0; m_t = 0; m_o = 0; m_cnt = 0; m_mag = 0; m_dn = 0;
    endtask

    task automatic model_step(input bit c, input bit s, input bit st, input bit kv,
                              input int kd, input bit tk, input bit dr);
        int n;
        if (c) begin
            model_reset();
        end else if (m_st == S_IDLE || m_st == S_ENTRY) begin
            if (!s) begin
                if (st) begin
                    if (dr && secs() != 0) begin m_st = S_RUN; m_mag = 1; end
                end else if (kv && kd <= 9 && m_o <= 5 && m_t <= MAX_MIN) begin
                    m_m = m_t; m_t = m_o; m_o = kd; m_st = S_ENTRY;
                end
            end
        end else if (m_st == S_PAUSE) begin
            if (!s && st && dr && secs() != 0) begin m_st = S_RUN; m_mag = 1; end
        end else if (m_st == S_RUN) begin
            if (s || !dr) begin
                m_st = S_PAUSE; m_mag = 0;
            end else if (tk) begin
                n = secs() - 1;
                m_m = n / 60; m_t = (n % 60) / 10; m_o = n % 10;
                if (n == 0) begin m_st = S_DONE; m_mag = 0; m_dn = 1; m_cnt = 0; end
            end
        end else if (m_st == S_DONE) begin
            if (tk) begin
                m_cnt++;
                if (m_cnt == DONE_TICKS) begin m_st = S_IDLE; m_dn = 0; m_cnt = 0; end
            end
        end
    endtask

    task automatic step(input bit c, input bit s, input bit st, input bit kv,
                        input int kd, input bit tk);
        exp_t e;
        @(negedge clk);
        clear = c; stop = s; start = st; key_valid = kv;
        key_data = 4'(kd); tick = tk; door_closed = door;
        if (!clrn) model_reset();
        else model_step(c, s, st, kv, kd, tk, door);
        e.st = m_st; e.m = m_m; e.t = m_t; e.o = m_o; e.mag = m_mag; e.dn = m_dn;
        exp_q.push_back(e);
    endtask

    task automatic key(input int d);  step(0, 0, 0, 1, d, 0); endtask
    task automatic go();              step(0, 0, 1, 0, 0, 0); endtask
    task automatic clr();             step(1, 0, 0, 0, 0, 0); endtask
    task automatic ticks(input int n); repeat (n) step(0, 0, 0, 0, 0, 1); endtask
    task automatic idle(input int n);  repeat (n) step(0, 0, 0, 0, 0, 0); endtask

    task automatic check_now(input string name, input exp_t e);
        checks++;
        if (int'(state) != e.st || int'(min_ones) != e.m || int'(sec_tens) != e.t ||
            int'(sec_ones) != e.o || mag_on != e.mag || done != e.dn) begin
            errors++;
            $display("FAIL %s @%0t: got st=%0d %0d:%0d%0d mag=%b done=%b, expected st=%0d %0d:%0d%0d mag=%b done=%b",
                     name, $time, state, min_ones, sec_tens, sec_ones, mag_on, done,
                     e.st, e.m, e.t, e.o, e.mag, e.dn);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_now("cycle", e);
            end
        end
    end

    initial begin
        exp_t z;
        z.st = S_IDLE; z.m = 0; z.t = 0; z.o = 0; z.mag = 0; z.dn = 0;

        // Power-on reset.
        #1 clrn = 1'b0;
        #2 check_now("reset", z);
        repeat (2) @(posedge clk);
        @(negedge clk) clrn = 1'b1;

        // Entry, then rejected key when sec_ones would become tens > 5.
        key(1); key(3); key(0);
        clr();
        key(1); key(7); key(0);
        clr();

        // Countdown wrap 1:00 -> 0:59 -> 0:00 -> DONE -> IDLE.
        key(1); key(0); key(0); go();
        ticks(1); ticks(59); idle(2); ticks(3);

        // Pause via door, ignored start with door open, resume.
        key(1); key(0); go(); ticks(4);
        door = 0; idle(1); ticks(2); go();
        door = 1; go(); ticks(6); ticks(3);

        // stop+tick together, then clear+start together.
        key(5); go();
        step(0, 1, 0, 0, 0, 1);
        go(); ticks(1);
        step(1, 0, 1, 0, 0, 0);

        // Guards: start at 0:00, invalid key, key during RUN.
        go(); key(12); key(3); key(0); go(); key(4); ticks(2); clr();

        // DONE is not shortened by an open door; start/key ignored there.
        key(2); go(); ticks(2);
        door = 0; go(); key(5); ticks(1); ticks(2); door = 1; idle(1);

        // Asynchronous reset mid-RUN at 0:42.
        key(4); key(2); go();
        @(posedge clk);
        #3 clrn = 1'b0;
        #1 check_now("async_reset", z);
        model_reset();
        step(0, 0, 0, 0, 0, 1); step(0, 0, 1, 0, 0, 1);
        clrn = 1'b1;
        ticks(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) door = ~door;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
        end
        door = 1; idle(1);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
